psum_accum_sfp: RTL and testbench
=================================

PSUM_ACCUM_SFP -- requirements
Module: psum_accum_sfp

Interface
REQ-001 The block SHALL have parameter col, default 8, meaning the number of output columns (lanes).
REQ-002 The block SHALL have parameter psum_bw, default 16, meaning the signed partial-sum width per lane.
REQ-003 The block SHALL have parameter addr_bw, default 11, meaning the psum SRAM address width (2048 words).
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 base_addr  input  addr_bw  first psum word address; latched on start.
REQ-008 num_acc  input  4  psum words summed per output (kernel positions); latched on start; 0 is treated as 1.
REQ-009 num_out  input  6  outputs per job; latched on start.
REQ-010 psum_cen  output  1  SRAM chip enable, active-low.
REQ-011 psum_wen  output  1  SRAM write enable, active-low; the block SHALL hold it at 1 (read-only).
REQ-012 psum_a  output  addr_bw  SRAM address.
REQ-013 psum_q  input  psum_bw*col  SRAM read data, valid the cycle after a read is issued.
REQ-014 out_valid  output  1  out_data is valid.
REQ-015 out_ready  input  1  consumer accepts out_data.
REQ-016 out_data  output  psum_bw*col  ReLU'd accumulated row; lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at job completion.

Function
REQ-019 The FSM SHALL have states IDLE, READ, DRAIN, EMIT and FIN.
REQ-020 IDLE->READ on start with num_out != 0; IDLE->FIN on start with num_out == 0, issuing no reads.
REQ-021 In READ, the block SHALL issue exactly N = max(num_acc, 1) consecutive reads with psum_cen=0, then move to DRAIN.
- Addresses: sequential from the running pointer, one per cycle.
- Pointer: starts at base_addr and is never reset between outputs.
REQ-022 The address pointer SHALL wrap from 2^addr_bw-1 to 0.
REQ-023 psum_cen SHALL be 1 in every state except READ.
REQ-024 Each psum_q word SHALL be added per lane to the accumulator at the edge ending the cycle after its read.
- Read-valid: a registered rd_vld tracks which cycles carry valid data.
REQ-025 The accumulator SHALL be cleared as the first read of each output is issued.
REQ-026 Lane addition SHALL be signed with saturation to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-027 DRAIN SHALL last one cycle (the final data word is accumulated), then move to EMIT.
REQ-028 In EMIT, out_valid SHALL be 1 and out_data = max(acc, 0) per lane (registered).
- out_data SHALL be held stable until a cycle with out_ready=1.
REQ-029 Latency: first out_valid SHALL occur N+2 cycles after the cycle start is sampled.
REQ-030 On handshake (out_valid & out_ready), the block SHALL go to READ if outputs remain, else to FIN.
- The same-cycle handshake and last-output case SHALL go to FIN.
REQ-031 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-032 start asserted while busy SHALL be ignored, with no effect on latched parameters.
REQ-033 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-034 Reset SHALL asynchronously force:
- FSM to IDLE.
- psum_cen=1, psum_wen=1, psum_a=0.
- out_valid=0, out_data=0.
- busy=0, done=0.
- Accumulators, counters and rd_vld to 0.
REQ-035 Reset asserted mid-job SHALL abandon the job; no done pulse SHALL follow and no stale out_valid SHALL appear after release.

Structure
REQ-036 A shared package SHALL hold:
- The FSM state enum.
- Width constants: psum_bw, col, addr_bw, num_acc width (4), num_out width (6).
- The saturation limits.
REQ-037 One sub-module, sfp_lane, SHALL implement per-lane saturating accumulate, clear and ReLU; the top SHALL instantiate it col times.

Verification
REQ-038 Single output: base=0, num_acc=3, num_out=1; every lane of words 0,1,2 = 5, -2, 10 -> reads at addr 0,1,2; out_data lanes=13; out_valid 5 cycles after start; done once.
REQ-039 ReLU and saturation: lane0 = 30000+30000 -> 32767; lane1 = -30000+-30000 -> 0 (clamped to -32768, then ReLU).
REQ-040 Backpressure and wrap: base=2046, num_acc=2, num_out=2, out_ready low 4 cycles on output 0 -> out_data held stable; reads at 2046,2047,0,1; no reads during the stall.
REQ-041 Degenerate: num_out=0 -> no psum_cen=0 cycle, done 1 cycle after start; num_acc=0 -> exactly one read per output.
REQ-042 Reset mid-READ of a 9x4 job -> all REQ-034 values within the reset cycle; no done; a new start after release runs correctly from its new base_addr.
REQ-043 start pulsed during EMIT -> ignored; address sequence and output count unchanged.

Source files
------------

// File: rtl/psum_accum_sfp_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths,
// job-field widths, saturation limits and the controller state type.
package psum_accum_sfp_pkg;

  localparam int def_col     = 8;
  localparam int def_psum_bw = 16;
  localparam int def_addr_bw = 11;
  localparam int num_acc_bw  = 4;
  localparam int num_out_bw  = 6;

  // Signed clamp limits of one lane at the default partial-sum width
  localparam logic signed [def_psum_bw-1:0] sat_max = {1'b0, {(def_psum_bw-1){1'b1}}};
  localparam logic signed [def_psum_bw-1:0] sat_min = {1'b1, {(def_psum_bw-1){1'b0}}};

  typedef enum logic [2:0] {
    st_idle,
    st_read,
    st_drain,
    st_emit,
    st_fin
  } state_t;

endpackage

// File: rtl/psum_accum_sfp_if.sv
// Bus bundle between the accumulator and its surroundings: the read-only
// psum SRAM port plus the valid/ready output stream of ReLU'd rows.
interface psum_accum_sfp_if #(
  parameter int col     = psum_accum_sfp_pkg::def_col,
  parameter int psum_bw = psum_accum_sfp_pkg::def_psum_bw,
  parameter int addr_bw = psum_accum_sfp_pkg::def_addr_bw
) ();

  logic                     psum_cen;
  logic                     psum_wen;
  logic [addr_bw-1:0]       psum_a;
  logic [psum_bw*col-1:0]   psum_q;
  logic                     out_valid;
  logic                     out_ready;
  logic [psum_bw*col-1:0]   out_data;

  modport master (
    output psum_cen, psum_wen, psum_a, out_valid, out_data,
    input  psum_q, out_ready
  );

  modport slave (
    input  psum_cen, psum_wen, psum_a, out_valid, out_data,
    output psum_q, out_ready
  );

endinterface

// File: rtl/psum_accum_sfp_lane.sv
// One output lane: signed saturating accumulator with clear, plus a
// registered ReLU result that stays put until the next load.
module sfp_lane
  import psum_accum_sfp_pkg::*;
#(
  parameter int psum_bw = def_psum_bw
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      add_en,
  input  logic                      load_out,
  input  logic signed [psum_bw-1:0] word,
  output logic        [psum_bw-1:0] out
);

  // Same limits as the package constants, derived for this lane's width
  localparam logic signed [psum_bw-1:0] lim_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] lim_min = {1'b1, {(psum_bw-1){1'b0}}};

  logic signed [psum_bw-1:0] acc;
  logic signed [psum_bw-1:0] acc_next;
  logic        [psum_bw:0]   wide_sum;

  // Sign-extended add; a mismatch of the top two bits means overflow, clamp by direction
  always_comb begin
    wide_sum = {acc[psum_bw-1], acc} + {word[psum_bw-1], word};
    acc_next = acc;
    if (add_en) begin
      if (wide_sum[psum_bw] != wide_sum[psum_bw-1]) begin
        acc_next = wide_sum[psum_bw] ? lim_min : lim_max;
      end else begin
        acc_next = wide_sum[psum_bw-1:0];
      end
    end
  end

  // Accumulator and output register; the output captures ReLU of the final sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      out <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else begin
        acc <= acc_next;
      end
      if (load_out) begin
        out <= acc_next[psum_bw-1] ? '0 : acc_next;
      end
    end
  end

endmodule

// File: rtl/psum_accum_sfp.sv
// Partial-sum accumulator: for each output, reads num_acc consecutive psum
// words from SRAM, sums them per lane with saturation, and emits the ReLU'd
// row over a valid/ready stream. The address pointer runs across outputs.
module psum_accum_sfp
  import psum_accum_sfp_pkg::*;
#(
  parameter int col     = def_col,
  parameter int psum_bw = def_psum_bw,
  parameter int addr_bw = def_addr_bw
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_bw-1:0]    base_addr,
  input  logic [num_acc_bw-1:0] num_acc,
  input  logic [num_out_bw-1:0] num_out,
  output logic                  busy,
  output logic                  done,
  psum_accum_sfp_if.master      bus
);

  state_t state;
  state_t state_next;

  logic [addr_bw-1:0]    ptr;
  logic [num_acc_bw-1:0] n_acc;
  logic [num_acc_bw-1:0] rd_cnt;
  logic [num_out_bw-1:0] out_left;
  logic                  rd_vld;

  logic                  rd_en;
  logic                  emit;
  logic                  last_rd;
  logic                  acc_clear;
  logic                  load_out;
  logic [col-1:0][psum_bw-1:0] lane_out;

  assign last_rd   = (rd_cnt == n_acc - 4'd1);
  assign acc_clear = (state == st_read) && (rd_cnt == '0);
  assign load_out  = (state == st_drain);

  assign bus.psum_cen  = ~rd_en;
  assign bus.psum_wen  = 1'b1;
  assign bus.psum_a    = ptr;
  assign bus.out_valid = emit;
  assign bus.out_data  = lane_out;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_idle;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    emit       = 1'b0;
    done       = 1'b0;
    busy       = (state != st_idle);
    case (state)
      st_idle: begin
        if (start) begin
          state_next = (num_out == '0) ? st_fin : st_read;
        end
      end
      st_read: begin
        rd_en = 1'b1;
        if (last_rd) begin
          state_next = st_drain;
        end
      end
      st_drain: begin
        state_next = st_emit;
      end
      st_emit: begin
        emit = 1'b1;
        if (bus.out_ready) begin
          state_next = (out_left == 6'd1) ? st_fin : st_read;
        end
      end
      st_fin: begin
        done       = 1'b1;
        state_next = st_idle;
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // Job parameters, address pointer, read counter and read-valid tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      n_acc    <= '0;
      rd_cnt   <= '0;
      out_left <= '0;
      rd_vld   <= 1'b0;
    end else begin
      rd_vld <= (state == st_read);
      case (state)
        st_idle: begin
          if (start) begin
            ptr      <= base_addr;
            n_acc    <= (num_acc == '0) ? 4'd1 : num_acc;
            out_left <= num_out;
            rd_cnt   <= '0;
          end
        end
        st_read: begin
          ptr    <= ptr + 1'b1;
          rd_cnt <= last_rd ? '0 : rd_cnt + 4'd1;
        end
        st_emit: begin
          if (bus.out_ready) begin
            out_left <= out_left - 6'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(
      .psum_bw(psum_bw)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear    (acc_clear),
      .add_en   (rd_vld),
      .load_out (load_out),
      .word     (bus.psum_q[psum_bw*i +: psum_bw]),
      .out      (lane_out[i])
    );
  end

endmodule

// File: tb/tb_psum_accum_sfp.sv
// Directed bench for psum_accum_sfp: behavioural SRAM, read-address log,
// done/handshake counters and hand-computed expected rows.
module tb_psum_accum_sfp;
  import psum_accum_sfp_pkg::*;

  localparam int w = def_psum_bw * def_col;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] base_addr;
  logic [3:0]  num_acc;
  logic [5:0]  num_out;
  logic        busy;
  logic        done;

  psum_accum_sfp_if bus_if ();

  psum_accum_sfp dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_acc   (num_acc),
    .num_out   (num_out),
    .busy      (busy),
    .done      (done),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  logic [w-1:0]  mem [0:2047];
  logic [10:0]   rd_log [$];
  int            done_cnt = 0;
  int            hs_cnt = 0;
  int            checks = 0;
  int            errors = 0;

  // SRAM model: one-cycle read latency
  always @(posedge clk) begin
    if (!bus_if.psum_cen) bus_if.psum_q <= mem[bus_if.psum_a];
  end

  // Log issued reads, done pulses and output handshakes
  always @(posedge clk) begin
    if (!reset && !bus_if.psum_cen) rd_log.push_back(bus_if.psum_a);
    if (!reset && done) done_cnt++;
    if (!reset && bus_if.out_valid && bus_if.out_ready) hs_cnt++;
  end

  // Run-time limit
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [w-1:0] obs, input logic [w-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [w-1:0] splat(input logic [15:0] v);
    return {def_col{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [10:0] b, input logic [3:0] na, input logic [5:0] no);
    base_addr = b;
    num_acc   = na;
    num_out   = no;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (bus_if.out_valid !== 1'b1 && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic accept();
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic check_read(input string tag, input int idx, input logic [10:0] exp);
    check_output(tag, w'(rd_log[idx]), w'(exp));
  endtask

  initial begin
    int lat;
    int n0;
    int d0;
    int h0;
    logic any_valid;
    logic [w-1:0] held;
    logic [w-1:0] wa;
    logic [w-1:0] wb;
    logic [w-1:0] wexp;

    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_acc = '0;
    num_out = '0;
    bus_if.out_ready = 1'b0;
    bus_if.psum_q = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;

    #1;
    check_output("rst_cen", w'(bus_if.psum_cen), w'(1));
    check_output("rst_wen", w'(bus_if.psum_wen), w'(1));
    check_output("rst_a", w'(bus_if.psum_a), w'(0));
    check_output("rst_valid", w'(bus_if.out_valid), w'(0));
    check_output("rst_data", bus_if.out_data, '0);
    check_output("rst_busy", w'(busy), w'(0));
    check_output("rst_done", w'(done), w'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single output, N=3: 5 + -2 + 10 = 13
    mem[0] = splat(16'd5);
    mem[1] = splat(16'hFFFE);
    mem[2] = splat(16'd10);
    n0 = rd_log.size();
    d0 = done_cnt;
    apply_stimulus(11'd0, 4'd3, 6'd1);
    wait_valid(20, lat);
    check_output("t1_latency", w'(lat + 1), w'(5));
    check_output("t1_data", bus_if.out_data, splat(16'd13));
    accept();
    check_output("t1_done", w'(done), w'(1));
    check_output("t1_fin_valid", w'(bus_if.out_valid), w'(0));
    tick();
    check_output("t1_done_low", w'(done), w'(0));
    check_output("t1_idle_busy", w'(busy), w'(0));
    check_output("t1_done_cnt", w'(done_cnt - d0), w'(1));
    check_output("t1_nreads", w'(rd_log.size() - n0), w'(3));
    check_read("t1_rd0", n0, 11'd0);
    check_read("t1_rd1", n0 + 1, 11'd1);
    check_read("t1_rd2", n0 + 2, 11'd2);

    // Saturation and ReLU per lane
    wa = splat(16'd7);
    wb = splat(16'd8);
    wexp = splat(16'd15);
    wa[15:0]  = 16'h7530; wb[15:0]  = 16'h7530; wexp[15:0]  = 16'h7FFF;
    wa[31:16] = 16'h8AD0; wb[31:16] = 16'h8AD0; wexp[31:16] = 16'h0000;
    wa[47:32] = 16'h0064; wb[47:32] = 16'hFED4; wexp[47:32] = 16'h0000;
    mem[10] = wa;
    mem[11] = wb;
    apply_stimulus(11'd10, 4'd2, 6'd1);
    wait_valid(20, lat);
    check_output("t2_latency", w'(lat + 1), w'(4));
    check_output("t2_data", bus_if.out_data, wexp);
    accept();
    tick();

    // Backpressure on output 0 and address wrap
    mem[2046] = splat(16'd1);
    mem[2047] = splat(16'd2);
    mem[0]    = splat(16'd3);
    mem[1]    = splat(16'd4);
    n0 = rd_log.size();
    apply_stimulus(11'd2046, 4'd2, 6'd2);
    wait_valid(20, lat);
    check_output("t3_latency", w'(lat + 1), w'(4));
    check_output("t3_data0", bus_if.out_data, splat(16'd3));
    held = bus_if.out_data;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("t3_stall_valid", w'(bus_if.out_valid), w'(1));
      check_output("t3_stall_data", bus_if.out_data, held);
    end
    check_output("t3_stall_reads", w'(rd_log.size() - n0), w'(2));
    accept();
    wait_valid(20, lat);
    check_output("t3_data1", bus_if.out_data, splat(16'd7));
    accept();
    check_output("t3_done", w'(done), w'(1));
    tick();
    check_output("t3_nreads", w'(rd_log.size() - n0), w'(4));
    check_read("t3_rd0", n0, 11'd2046);
    check_read("t3_rd1", n0 + 1, 11'd2047);
    check_read("t3_rd2", n0 + 2, 11'd0);
    check_read("t3_rd3", n0 + 3, 11'd1);

    // num_out = 0: straight to FIN, no reads
    n0 = rd_log.size();
    apply_stimulus(11'd500, 4'd3, 6'd0);
    check_output("t4_done", w'(done), w'(1));
    check_output("t4_busy", w'(busy), w'(1));
    tick();
    check_output("t4_done_low", w'(done), w'(0));
    check_output("t4_idle", w'(busy), w'(0));
    check_output("t4_nreads", w'(rd_log.size() - n0), w'(0));

    // num_acc = 0 behaves as a single read per output
    mem[100] = splat(16'd9);
    mem[101] = splat(16'd6);
    n0 = rd_log.size();
    apply_stimulus(11'd100, 4'd0, 6'd2);
    wait_valid(20, lat);
    check_output("t5_latency", w'(lat + 1), w'(3));
    check_output("t5_data0", bus_if.out_data, splat(16'd9));
    accept();
    wait_valid(20, lat);
    check_output("t5_data1", bus_if.out_data, splat(16'd6));
    accept();
    check_output("t5_done", w'(done), w'(1));
    tick();
    check_output("t5_nreads", w'(rd_log.size() - n0), w'(2));
    check_read("t5_rd0", n0, 11'd100);
    check_read("t5_rd1", n0 + 1, 11'd101);

    // Reset in the middle of a 9x4 job
    d0 = done_cnt;
    apply_stimulus(11'd200, 4'd9, 6'd4);
    tick();
    reset = 1'b1;
    #1;
    check_output("t6_cen", w'(bus_if.psum_cen), w'(1));
    check_output("t6_wen", w'(bus_if.psum_wen), w'(1));
    check_output("t6_a", w'(bus_if.psum_a), w'(0));
    check_output("t6_valid", w'(bus_if.out_valid), w'(0));
    check_output("t6_data", bus_if.out_data, '0);
    check_output("t6_busy", w'(busy), w'(0));
    check_output("t6_done", w'(done), w'(0));
    tick();
    tick();
    reset = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any_valid = any_valid | bus_if.out_valid;
    end
    check_output("t6_no_valid", w'(any_valid), w'(0));
    check_output("t6_no_done", w'(done_cnt - d0), w'(0));
    mem[300] = splat(16'd20);
    mem[301] = splat(16'hFFFC);
    n0 = rd_log.size();
    apply_stimulus(11'd300, 4'd2, 6'd1);
    wait_valid(20, lat);
    check_output("t6_latency", w'(lat + 1), w'(4));
    check_output("t6_new_data", bus_if.out_data, splat(16'd16));
    accept();
    tick();
    check_output("t6_done_cnt", w'(done_cnt - d0), w'(1));
    check_output("t6_nreads", w'(rd_log.size() - n0), w'(2));
    check_read("t6_rd0", n0, 11'd300);
    check_read("t6_rd1", n0 + 1, 11'd301);

    // start pulsed during EMIT is ignored
    mem[400] = splat(16'd11);
    mem[401] = splat(16'd12);
    n0 = rd_log.size();
    h0 = hs_cnt;
    apply_stimulus(11'd400, 4'd1, 6'd2);
    wait_valid(20, lat);
    check_output("t7_data0", bus_if.out_data, splat(16'd11));
    base_addr = 11'd0;
    num_acc = 4'd5;
    num_out = 6'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("t7_still_valid", w'(bus_if.out_valid), w'(1));
    check_output("t7_still_data", bus_if.out_data, splat(16'd11));
    accept();
    wait_valid(20, lat);
    check_output("t7_latency1", w'(lat + 1), w'(3));
    check_output("t7_data1", bus_if.out_data, splat(16'd12));
    accept();
    check_output("t7_done", w'(done), w'(1));
    tick();
    check_output("t7_outputs", w'(hs_cnt - h0), w'(2));
    check_output("t7_nreads", w'(rd_log.size() - n0), w'(2));
    check_read("t7_rd0", n0, 11'd400);
    check_read("t7_rd1", n0 + 1, 11'd401);
    check_output("t7_idle", w'(busy), w'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
